// File: rtl/sga_serial_cmd_rx.sv
// Serial command receiver for the Snake Game Arcade.
// Receives 7O1 UART frames, checks parity and stop bit, and turns ASCII keys
// into one-cycle command pulses for the game controller.
//
// state  | code | meaning
// -------+------+------------------------------------------------------
// IDLE   |  0   | line idle; waiting for a falling edge while enabled
// START  |  1   | half a bit period into the start bit; glitch filter
// DATA   |  2   | sampling 7 data bits, LSB first, one per bit period
// PARITY |  3   | sampling the odd-parity bit
// STOP   |  4   | sampling the stop bit (mid-bit, so back-to-back works)
// DECODE |  5   | single cycle; registers error/valid/command pulses
module sga_serial_cmd_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_serial,
  input  logic       enable,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       start,
  output logic       pause,
  output logic       restart_cmd,
  output logic       pronto,
  output logic [6:0] dado,
  output logic       parity_error,
  output logic       frame_error,
  output logic [2:0] db_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DECODE = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [6:0]      shift_reg;
  logic            par_bit;
  logic            stop_bit;
  logic            rx_meta;
  logic            rx_sync;
  logic            bit_tick;
  logic            parity_ok;
  logic [6:0]      key_lower;
  logic [6:0]      cmd_vec;

  // Two-flop synchronizer, preset high so reset release never looks like a start edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
    end
  end

  assign bit_tick  = (baud_cnt == BIT_LAST);
  assign parity_ok = ^{shift_reg, par_bit};
  // Setting bit 5 folds 'A'..'Z' onto 'a'..'z'; only the letters themselves land on the map keys
  assign key_lower = shift_reg | 7'h20;

  // Key map: bit order left, right, up, down, start, pause, restart
  always_comb begin
    cmd_vec = 7'b0;
    case (key_lower)
      7'h61:   cmd_vec[0] = 1'b1;
      7'h64:   cmd_vec[1] = 1'b1;
      7'h77:   cmd_vec[2] = 1'b1;
      7'h73:   cmd_vec[3] = 1'b1;
      7'h69:   cmd_vec[4] = 1'b1;
      7'h70:   cmd_vec[5] = 1'b1;
      7'h72:   cmd_vec[6] = 1'b1;
      default: cmd_vec = 7'b0;
    endcase
  end

  // Receive FSM with registered pulse outputs and held character
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= 3'd0;
      shift_reg    <= 7'h00;
      par_bit      <= 1'b0;
      stop_bit     <= 1'b0;
      left         <= 1'b0;
      right        <= 1'b0;
      up           <= 1'b0;
      down         <= 1'b0;
      start        <= 1'b0;
      pause        <= 1'b0;
      restart_cmd  <= 1'b0;
      pronto       <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      dado         <= 7'h00;
    end else begin
      left         <= 1'b0;
      right        <= 1'b0;
      up           <= 1'b0;
      down         <= 1'b0;
      start        <= 1'b0;
      pause        <= 1'b0;
      restart_cmd  <= 1'b0;
      pronto       <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= 3'd0;
          if (enable && !rx_sync) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            baud_cnt  <= '0;
            shift_reg <= {rx_sync, shift_reg[6:1]};
            if (bit_cnt == 3'd6) begin
              bit_cnt <= 3'd0;
              state   <= S_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            baud_cnt <= '0;
            par_bit  <= rx_sync;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            baud_cnt <= '0;
            stop_bit <= rx_sync;
            state    <= S_DECODE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          baud_cnt <= '0;
          state    <= S_IDLE;
          if (!stop_bit) begin
            frame_error <= 1'b1;
          end else if (!parity_ok) begin
            parity_error <= 1'b1;
          end else begin
            pronto      <= 1'b1;
            dado        <= shift_reg;
            left        <= cmd_vec[0];
            right       <= cmd_vec[1];
            up          <= cmd_vec[2];
            down        <= cmd_vec[3];
            start       <= cmd_vec[4];
            pause       <= cmd_vec[5];
            restart_cmd <= cmd_vec[6];
          end
        end
        default: begin
          baud_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign db_state = state;

endmodule
